data_mem_responder: RTL and testbench

//  Responder end of the pipeline's data-memory interface. Accepts load/store requests

---
 rtl/data_mem_responder.sv | 199 +++++++++++++++++++
 tb/tb_data_mem_responder.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Responder end of the data-memory interface: word RAM with wait states, byte-lane stores, load extension.
// Optional `DMEM_MISALIGN_ERR_EN: misaligned half/word accesses report o_RspErr and skip the RAM write.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic        i_Clk,
  input  logic        i_Reset,
  input  logic        i_ReqValid,
  output logic        o_ReqReady,
  input  logic        i_ReqWrite,
  input  logic [31:0] i_ReqAddr,
  input  logic [1:0]  i_ReqSize,
  input  logic        i_ReqUnsigned,
  input  logic [31:0] i_ReqWData,
  output logic        o_RspValid,
  output logic [31:0] o_RspRData,
  output logic        o_RspErr,
  output logic        o_StallM
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;
  localparam logic [3:0] WS_INIT = 4'(WAIT_STATES - 1);

  logic [1:0]    state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          write_q;
  logic [AW+1:0] addr_q;
  logic [1:0]    size_q;
  logic          uns_q;
  logic [31:0]   wdata_q;
  logic          rsp_valid_q;
  logic [31:0]   rsp_rdata_q;
  logic          rsp_err_q;

  logic          accept_s, finish_s, we_s, misalign_s;
  logic          acc_wr_s, acc_uns_s;
  logic [AW+1:0] acc_addr_s;
  logic [1:0]    acc_size_s;
  logic [31:0]   acc_wdata_s;
  logic [AW-1:0] idx_s;
  logic [31:0]   rd_word_s, load_s, wlane_s;
  logic [3:0]    be_s;
  logic [7:0]    byte_s;
  logic [15:0]   half_s;
  logic          unused_addr_s;

  logic [31:0] mem [DEPTH_WORDS];

  assign unused_addr_s = ^i_ReqAddr[31:AW+2];

  // Next-state logic; finish_s marks the edge that performs the RAM access.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    accept_s = 1'b0;
    finish_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_ReqValid) begin
          accept_s = 1'b1;
          if (WAIT_STATES == 0) begin
            state_d  = ST_RESP;
            finish_s = 1'b1;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = WS_INIT;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d  = ST_RESP;
          finish_s = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // With zero wait states the access completes on the accept edge, so use live inputs in IDLE.
  always_comb begin
    if (state_q == ST_IDLE) begin
      acc_wr_s    = i_ReqWrite;
      acc_addr_s  = i_ReqAddr[AW+1:0];
      acc_size_s  = i_ReqSize;
      acc_uns_s   = i_ReqUnsigned;
      acc_wdata_s = i_ReqWData;
    end else begin
      acc_wr_s    = write_q;
      acc_addr_s  = addr_q;
      acc_size_s  = size_q;
      acc_uns_s   = uns_q;
      acc_wdata_s = wdata_q;
    end
  end

  assign idx_s     = acc_addr_s[AW+1:2];
  assign rd_word_s = mem[idx_s];

`ifdef DMEM_MISALIGN_ERR_EN
  assign misalign_s = ((acc_size_s == 2'b01) && acc_addr_s[0]) ||
                      (acc_size_s[1] && (acc_addr_s[1:0] != 2'b00));
`else
  assign misalign_s = 1'b0;
`endif

  // Store lane enables and replicated store data.
  always_comb begin
    case (acc_size_s)
      2'b00: begin
        be_s    = 4'b0001 << acc_addr_s[1:0];
        wlane_s = {4{acc_wdata_s[7:0]}};
      end
      2'b01: begin
        be_s    = acc_addr_s[1] ? 4'b1100 : 4'b0011;
        wlane_s = {2{acc_wdata_s[15:0]}};
      end
      default: begin
        be_s    = 4'b1111;
        wlane_s = acc_wdata_s;
      end
    endcase
  end

  assign byte_s = rd_word_s[{acc_addr_s[1:0], 3'b000} +: 8];
  assign half_s = acc_addr_s[1] ? rd_word_s[31:16] : rd_word_s[15:0];

  // Load lane selection and sign/zero extension.
  always_comb begin
    case (acc_size_s)
      2'b00:   load_s = acc_uns_s ? {24'd0, byte_s} : {{24{byte_s[7]}}, byte_s};
      2'b01:   load_s = acc_uns_s ? {16'd0, half_s} : {{16{half_s[15]}}, half_s};
      default: load_s = rd_word_s;
    endcase
  end

  assign we_s = finish_s && acc_wr_s && !misalign_s && i_Reset;

  // RAM write port; contents survive reset.
  always_ff @(posedge i_Clk) begin
    if (we_s) begin
      for (int b = 0; b < 4; b++) begin
        if (be_s[b]) begin
          mem[idx_s][8*b +: 8] <= wlane_s[8*b +: 8];
        end
      end
    end
  end

  // Control state, request latch and registered response.
  always_ff @(posedge i_Clk) begin
    if (!i_Reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      size_q      <= 2'b00;
      uns_q       <= 1'b0;
      wdata_q     <= 32'd0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept_s) begin
        write_q <= i_ReqWrite;
        addr_q  <= i_ReqAddr[AW+1:0];
        size_q  <= i_ReqSize;
        uns_q   <= i_ReqUnsigned;
        wdata_q <= i_ReqWData;
      end
      rsp_valid_q <= finish_s;
      if (finish_s) begin
        rsp_rdata_q <= (acc_wr_s || misalign_s) ? 32'd0 : load_s;
        rsp_err_q   <= misalign_s;
      end else begin
        rsp_rdata_q <= 32'd0;
        rsp_err_q   <= 1'b0;
      end
    end
  end

  assign o_ReqReady = (state_q == ST_IDLE);
  assign o_StallM   = ((state_q == ST_IDLE) && i_ReqValid) || (state_q == ST_WAIT);
  assign o_RspValid = rsp_valid_q;
  assign o_RspRData = rsp_rdata_q;
  assign o_RspErr   = rsp_err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: three instances with 1, 3 and 0 wait states share one clock.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n [3];
  logic        req_valid [3];
  logic        req_ready [3];
  logic        req_write [3];
  logic [31:0] req_addr [3];
  logic [1:0]  req_size [3];
  logic        req_uns [3];
  logic [31:0] req_wdata [3];
  logic        rsp_valid [3];
  logic [31:0] rsp_rdata [3];
  logic        rsp_err [3];
  logic        stall [3];

  int checks = 0;
  int errors = 0;
  int cycle_cnt = 0;
  int last_rsp [3];

  always #5 clk = ~clk;
  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    data_mem_responder #(
      .DEPTH_WORDS(1024),
      .WAIT_STATES((g == 0) ? 1 : ((g == 1) ? 3 : 0))
    ) u_dut (
      .i_Clk        (clk),
      .i_Reset      (rst_n[g]),
      .i_ReqValid   (req_valid[g]),
      .o_ReqReady   (req_ready[g]),
      .i_ReqWrite   (req_write[g]),
      .i_ReqAddr    (req_addr[g]),
      .i_ReqSize    (req_size[g]),
      .i_ReqUnsigned(req_uns[g]),
      .i_ReqWData   (req_wdata[g]),
      .o_RspValid   (rsp_valid[g]),
      .o_RspRData   (rsp_rdata[g]),
      .o_RspErr     (rsp_err[g]),
      .o_StallM     (stall[g])
    );
  end

  function automatic int ws_of(input int u);
    return (u == 0) ? 1 : ((u == 1) ? 3 : 0);
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // One complete access: present in IDLE, follow stall through WAIT, check the response.
  task automatic access(input int u, input logic wr, input logic [31:0] addr,
                        input logic [1:0] size, input logic uns, input logic [31:0] wdata,
                        input logic [31:0] exp_data, input logic exp_err, input string tag);
    int cyc;
    bit got;
    @(negedge clk);
    req_valid[u] = 1'b1;
    req_write[u] = wr;
    req_addr[u]  = addr;
    req_size[u]  = size;
    req_uns[u]   = uns;
    req_wdata[u] = wdata;
    #1;
    check_eq({tag, " ready_idle"}, 32'(req_ready[u]), 32'd1);
    check_eq({tag, " stall_accept"}, 32'(stall[u]), 32'd1);
    @(posedge clk);
    #1;
    req_valid[u] = 1'b0;
    req_wdata[u] = 32'h0BAD_0BAD;
    req_addr[u]  = 32'h0000_0FFC;
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (rsp_valid[u]) begin
        got = 1'b1;
      end else begin
        check_eq({tag, " stall_wait"}, 32'(stall[u]), 32'd1);
      end
    end
    check_eq({tag, " latency"}, 32'(cyc), 32'(ws_of(u) + 1));
    check_eq({tag, " rdata"}, rsp_rdata[u], exp_data);
    check_eq({tag, " err"}, 32'(rsp_err[u]), 32'(exp_err));
    check_eq({tag, " stall_resp"}, 32'(stall[u]), 32'd0);
    check_eq({tag, " ready_resp"}, 32'(req_ready[u]), 32'd0);
    last_rsp[u] = cycle_cnt;
  endtask

  initial begin
    int t0;
    bit mis_en;
`ifdef DMEM_MISALIGN_ERR_EN
    mis_en = 1'b1;
`else
    mis_en = 1'b0;
`endif
    for (int u = 0; u < 3; u++) begin
      rst_n[u]     = 1'b0;
      req_valid[u] = 1'b0;
      req_write[u] = 1'b0;
      req_addr[u]  = 32'd0;
      req_size[u]  = 2'b10;
      req_uns[u]   = 1'b0;
      req_wdata[u] = 32'd0;
      last_rsp[u]  = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int u = 0; u < 3; u++) rst_n[u] = 1'b1;
    @(negedge clk);
    for (int u = 0; u < 3; u++) begin
      check_eq($sformatf("reset ready%0d", u), 32'(req_ready[u]), 32'd1);
      check_eq($sformatf("reset valid%0d", u), 32'(rsp_valid[u]), 32'd0);
      check_eq($sformatf("reset stall%0d", u), 32'(stall[u]), 32'd0);
      check_eq($sformatf("reset rdata%0d", u), rsp_rdata[u], 32'd0);
      check_eq($sformatf("reset err%0d", u), 32'(rsp_err[u]), 32'd0);
    end

    // Word store/load and address aliasing above the RAM depth.
    access(0, 1'b1, 32'h10, 2'b10, 1'b0, 32'hDEADBEEF, 32'd0, 1'b0, "sw10");
    access(0, 1'b0, 32'h10, 2'b10, 1'b0, 32'd0, 32'hDEADBEEF, 1'b0, "lw10");
    access(0, 1'b0, 32'h1010, 2'b10, 1'b1, 32'd0, 32'hDEADBEEF, 1'b0, "lw_alias");

    // Byte lanes and extension.
    access(0, 1'b1, 32'h10, 2'b10, 1'b0, 32'h0, 32'd0, 1'b0, "sw10_zero");
    access(0, 1'b1, 32'h13, 2'b00, 1'b0, 32'hFFFFFF80, 32'd0, 1'b0, "sb13");
    access(0, 1'b0, 32'h13, 2'b00, 1'b0, 32'd0, 32'hFFFFFF80, 1'b0, "lb13");
    access(0, 1'b0, 32'h13, 2'b00, 1'b1, 32'd0, 32'h00000080, 1'b0, "lbu13");
    access(0, 1'b0, 32'h10, 2'b10, 1'b0, 32'd0, 32'h80000000, 1'b0, "lw10_b");
    access(0, 1'b0, 32'h12, 2'b00, 1'b0, 32'd0, 32'h00000000, 1'b0, "lb12");

    // Half lanes.
    access(0, 1'b1, 32'h20, 2'b10, 1'b0, 32'hCAFEF00D, 32'd0, 1'b0, "sw20");
    access(0, 1'b1, 32'h22, 2'b01, 1'b0, 32'hAAAA1234, 32'd0, 1'b0, "sh22");
    access(0, 1'b0, 32'h22, 2'b01, 1'b0, 32'd0, 32'h00001234, 1'b0, "lh22");
    access(0, 1'b0, 32'h20, 2'b01, 1'b0, 32'd0, 32'hFFFFF00D, 1'b0, "lh20");
    access(0, 1'b0, 32'h20, 2'b01, 1'b1, 32'd0, 32'h0000F00D, 1'b0, "lhu20");
    access(0, 1'b0, 32'h20, 2'b10, 1'b0, 32'd0, 32'h1234F00D, 1'b0, "lw20");
    access(0, 1'b0, 32'h20, 2'b11, 1'b1, 32'd0, 32'h1234F00D, 1'b0, "lw20_rsvd");

    // Misaligned word store.
    access(0, 1'b1, 32'h30, 2'b10, 1'b0, 32'hAAAAAAAA, 32'd0, 1'b0, "sw30");
    access(0, 1'b1, 32'h31, 2'b10, 1'b0, 32'h11111111, 32'd0, mis_en, "sw31_mis");
    access(0, 1'b0, 32'h30, 2'b10, 1'b0, 32'd0, mis_en ? 32'hAAAAAAAA : 32'h11111111, 1'b0, "lw30");
    access(0, 1'b0, 32'h21, 2'b01, 1'b0, 32'd0, mis_en ? 32'h0 : 32'hFFFFF00D, mis_en, "lh21_mis");

    // Reset during WAIT aborts the store and suppresses the response.
    access(1, 1'b1, 32'h40, 2'b10, 1'b0, 32'h00000077, 32'd0, 1'b0, "sw40_init");
    @(negedge clk);
    req_valid[1] = 1'b1;
    req_write[1] = 1'b1;
    req_addr[1]  = 32'h40;
    req_size[1]  = 2'b10;
    req_wdata[1] = 32'h5;
    @(posedge clk);
    #1;
    req_valid[1] = 1'b0;
    @(negedge clk);
    check_eq("abort in_wait", 32'(stall[1]), 32'd1);
    rst_n[1] = 1'b0;
    @(posedge clk);
    #1;
    rst_n[1] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_eq($sformatf("abort no_rsp%0d", i), 32'(rsp_valid[1]), 32'd0);
    end
    check_eq("abort ready", 32'(req_ready[1]), 32'd1);
    access(1, 1'b0, 32'h40, 2'b10, 1'b0, 32'd0, 32'h00000077, 1'b0, "lw40_after");

    // Zero wait states: back-to-back loads respond every two cycles.
    access(2, 1'b1, 32'h8, 2'b10, 1'b0, 32'h01020304, 32'd0, 1'b0, "ws0_sw8");
    access(2, 1'b0, 32'h8, 2'b10, 1'b0, 32'd0, 32'h01020304, 1'b0, "ws0_lw8a");
    t0 = last_rsp[2];
    access(2, 1'b0, 32'h9, 2'b00, 1'b1, 32'd0, 32'h00000003, 1'b0, "ws0_lbu9");
    check_eq("ws0 spacing1", 32'(last_rsp[2] - t0), 32'd2);
    t0 = last_rsp[2];
    access(2, 1'b0, 32'hA, 2'b01, 1'b0, 32'd0, 32'h00000102, 1'b0, "ws0_lhA");
    check_eq("ws0 spacing2", 32'(last_rsp[2] - t0), 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
